// File: rtl/pic_cmd_sequencer.sv
// PIC CPU-side command sequencer: synchronises bus strobes, walks the ICW init sequence, decodes OCWs.
// Define PIC_READBACK_EN to build the status read path (dout/bus_oe and the IRR/ISR read-select).
module pic_cmd_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic [7:0] irr_in,
    input  logic [7:0] isr_in,
    output logic [7:0] dout,
    output logic       bus_oe,
    output logic [7:0] imr,
    output logic [4:0] vec_base,
    output logic       ltim,
    output logic       sngl,
    output logic [7:0] icw3,
    output logic       aeoi,
    output logic       init_done,
    output logic       ocw2_stb,
    output logic [7:0] ocw2_cmd
);

    localparam logic [2:0] ST_UNINIT    = 3'd0;
    localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    // Synchroniser lanes packed as {a0, rd_n, wr_n, cs_n}; strobes idle high.
    localparam logic [3:0] SYNC_IDLE = 4'b0111;

    logic [3:0] sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= SYNC_IDLE;
                    else     sync_reg[gi] <= {a0, rd_n, wr_n, cs_n};
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= SYNC_IDLE;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    logic s_cs_n, s_wr_n, s_rd_n, s_a0;
    assign s_cs_n = sync_reg[SYNC_STAGES-1][0];
    assign s_wr_n = sync_reg[SYNC_STAGES-1][1];
    assign s_rd_n = sync_reg[SYNC_STAGES-1][2];
    assign s_a0   = sync_reg[SYNC_STAGES-1][3];

    logic [7:0] din_cap_reg;
    logic       a0_cap_reg;
    logic       cap_valid_reg;
    logic       wr_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_cap_reg   <= 8'h00;
            a0_cap_reg    <= 1'b0;
            cap_valid_reg <= 1'b0;
            wr_prev_reg   <= 1'b1;
        end else begin
            wr_prev_reg <= s_wr_n;
            if (!s_wr_n && !s_cs_n) begin
                din_cap_reg   <= din;
                a0_cap_reg    <= s_a0;
                cap_valid_reg <= 1'b1;
            end else if (s_wr_n) begin
                cap_valid_reg <= 1'b0;
            end
        end
    end

    // A write takes effect on the rising wr_n edge, only if cs_n was low during the strobe.
    logic commit, is_icw1;
    assign commit  = s_wr_n && !wr_prev_reg && cap_valid_reg;
    assign is_icw1 = commit && !a0_cap_reg && din_cap_reg[4];

    logic [2:0] state_reg;
    logic [7:0] imr_reg, icw3_reg, ocw2_cmd_reg;
    logic [4:0] vec_base_reg;
    logic       ltim_reg, sngl_reg, ic4_reg, aeoi_reg, init_done_reg, ocw2_stb_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_UNINIT;
            imr_reg       <= 8'h00;
            vec_base_reg  <= 5'd0;
            ltim_reg      <= 1'b0;
            sngl_reg      <= 1'b0;
            ic4_reg       <= 1'b0;
            icw3_reg      <= 8'h00;
            aeoi_reg      <= 1'b0;
            init_done_reg <= 1'b0;
            ocw2_stb_reg  <= 1'b0;
            ocw2_cmd_reg  <= 8'h00;
        end else begin
            ocw2_stb_reg <= 1'b0;
            if (is_icw1) begin
                ltim_reg      <= din_cap_reg[3];
                sngl_reg      <= din_cap_reg[1];
                ic4_reg       <= din_cap_reg[0];
                imr_reg       <= 8'h00;
                icw3_reg      <= 8'h00;
                aeoi_reg      <= 1'b0;
                init_done_reg <= 1'b0;
                state_reg     <= ST_WAIT_ICW2;
            end else if (commit && a0_cap_reg) begin
                case (state_reg)
                    ST_WAIT_ICW2: begin
                        vec_base_reg <= din_cap_reg[7:3];
                        if (!sngl_reg) begin
                            state_reg <= ST_WAIT_ICW3;
                        end else if (ic4_reg) begin
                            state_reg <= ST_WAIT_ICW4;
                        end else begin
                            state_reg     <= ST_READY;
                            init_done_reg <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        icw3_reg <= din_cap_reg;
                        if (ic4_reg) begin
                            state_reg <= ST_WAIT_ICW4;
                        end else begin
                            state_reg     <= ST_READY;
                            init_done_reg <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        aeoi_reg      <= din_cap_reg[1];
                        state_reg     <= ST_READY;
                        init_done_reg <= 1'b1;
                    end
                    ST_READY: imr_reg <= din_cap_reg;
                    default: ;
                endcase
            end else if (commit && state_reg == ST_READY && din_cap_reg[4:3] == 2'b00) begin
                ocw2_cmd_reg <= din_cap_reg;
                ocw2_stb_reg <= 1'b1;
            end
        end
    end

    assign imr       = imr_reg;
    assign vec_base  = vec_base_reg;
    assign ltim      = ltim_reg;
    assign sngl      = sngl_reg;
    assign icw3      = icw3_reg;
    assign aeoi      = aeoi_reg;
    assign init_done = init_done_reg;
    assign ocw2_stb  = ocw2_stb_reg;
    assign ocw2_cmd  = ocw2_cmd_reg;

`ifdef PIC_READBACK_EN
    logic       is_ocw3;
    logic       rsel_reg;
    logic [7:0] dout_reg;

    assign is_ocw3 = commit && state_reg == ST_READY && !a0_cap_reg && din_cap_reg[4:3] == 2'b01;

    // rsel_reg: 1 selects ISR, 0 selects IRR for a0=0 reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsel_reg <= 1'b0;
            dout_reg <= 8'h00;
        end else begin
            if (is_icw1)
                rsel_reg <= 1'b0;
            else if (is_ocw3 && din_cap_reg[1])
                rsel_reg <= din_cap_reg[0];
            dout_reg <= s_a0 ? imr_reg : (rsel_reg ? isr_in : irr_in);
        end
    end

    assign dout   = dout_reg;
    assign bus_oe = !s_rd_n && !s_cs_n && s_wr_n;
`else
    logic unused_readback;
    assign unused_readback = ^{s_rd_n, irr_in, isr_in};
    assign dout   = 8'h00;
    assign bus_oe = 1'b0;
`endif

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer: init sequences, OCW decode, status reads and reset behaviour.
module tb_pic_cmd_sequencer;

`ifdef PIC_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
    logic [7:0] din = 8'h00, irr_in = 8'h00, isr_in = 8'h00;
    logic [7:0] dout, imr, icw3, ocw2_cmd;
    logic [4:0] vec_base;
    logic       bus_oe, ltim, sngl, aeoi, init_done, ocw2_stb;

    int checks = 0;
    int errors = 0;
    int stb_count = 0;
    int stb_base;

    pic_cmd_sequencer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
        .din(din), .irr_in(irr_in), .isr_in(isr_in), .dout(dout), .bus_oe(bus_oe),
        .imr(imr), .vec_base(vec_base), .ltim(ltim), .sngl(sngl), .icw3(icw3),
        .aeoi(aeoi), .init_done(init_done), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ocw2_stb === 1'b1) stb_count++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        wr_n = 1'b1;
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        $display("write a0=%0d din=%02h", a, d);
    endtask

    task automatic cpu_read(input logic a, input string tag, input logic [7:0] exp_d, input logic exp_oe);
        @(negedge clk);
        cs_n = 1'b0; a0 = a; rd_n = 1'b0;
        repeat (5) @(negedge clk);
        check({tag, "_dout"}, {56'h0, dout}, {56'h0, exp_d});
        check({tag, "_oe"}, {63'h0, bus_oe}, {63'h0, exp_oe});
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return {18'h0, imr, vec_base, ltim, sngl, icw3, aeoi, init_done, ocw2_stb,
                ocw2_cmd, dout, bus_oe};
    endfunction

    initial begin
        // 1: reset, then reset again in the middle of an ICW1 write
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 64'h0);
        cs_n = 1'b0; a0 = 1'b0; din = 8'h13; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_midwrite_outs", all_outs(), 64'h0);
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_midwrite_done", {63'h0, init_done}, 64'h0);
        cpu_write(1'b1, 8'h55);
        check("uninit_ocw1_ignored", {56'h0, imr}, 64'h0);

        // 2: single mode with ICW4
        cpu_write(1'b0, 8'h13);
        check("icw1_sngl", {62'h0, ltim, sngl}, 64'h1);
        cpu_write(1'b1, 8'h40);
        check("icw2_vec", {59'h0, vec_base}, 64'h08);
        check("icw2_not_done", {63'h0, init_done}, 64'h0);
        cpu_write(1'b1, 8'h02);
        check("icw4_aeoi_done", {62'h0, aeoi, init_done}, 64'h3);
        check("icw3_skipped", {56'h0, icw3}, 64'h0);

        // 3: cascade mode with ICW3 and ICW4
        cpu_write(1'b0, 8'h11);
        check("icw1b_clears", {61'h0, sngl, aeoi, init_done}, 64'h0);
        cpu_write(1'b1, 8'h20);
        check("icw2b_vec", {59'h0, vec_base}, 64'h04);
        cpu_write(1'b1, 8'h04);
        check("icw3_val", {56'h0, icw3}, 64'h04);
        check("icw3_not_done", {63'h0, init_done}, 64'h0);
        cpu_write(1'b1, 8'h00);
        check("icw4b_done", {62'h0, aeoi, init_done}, 64'h1);

        // 4: OCW1 and OCW2
        cpu_write(1'b1, 8'hA5);
        check("ocw1_imr", {56'h0, imr}, 64'hA5);
        stb_base = stb_count;
        cpu_write(1'b0, 8'h20);
        check("ocw2_stb_cycles", 64'(stb_count - stb_base), 64'd1);
        check("ocw2_cmd", {56'h0, ocw2_cmd}, 64'h20);
        check("ocw2_stb_low", {63'h0, ocw2_stb}, 64'h0);

        // 5: OCW3 read-select and status reads
        irr_in = 8'h3C; isr_in = 8'h80;
        cpu_write(1'b0, 8'h0B);
        cpu_read(1'b0, "read_isr", RB ? 8'h80 : 8'h00, RB);
        cpu_write(1'b0, 8'h08);
        cpu_read(1'b0, "read_hold_isr", RB ? 8'h80 : 8'h00, RB);
        cpu_write(1'b0, 8'h0A);
        cpu_read(1'b0, "read_irr", RB ? 8'h3C : 8'h00, RB);
        cpu_read(1'b1, "read_imr", RB ? 8'hA5 : 8'h00, RB);

        // 6: ICW1 restart from WAIT_ICW3, simultaneous strobes, reset mid-read
        cpu_write(1'b0, 8'h11);
        cpu_write(1'b1, 8'h20);
        cpu_write(1'b0, 8'h11);
        check("restart_imr", {56'h0, imr}, 64'h0);
        check("restart_done", {63'h0, init_done}, 64'h0);
        cpu_write(1'b0, 8'h00);
        cpu_write(1'b1, 8'h48);
        check("restart_icw2_vec", {59'h0, vec_base}, 64'h09);
        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b0; din = 8'h00; wr_n = 1'b0; rd_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_wr_both_oe", {63'h0, bus_oe}, 64'h0);
        wr_n = 1'b1; rd_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check("wait_icw3_ignore", {56'h0, icw3}, 64'h0);
        cpu_write(1'b1, 8'h02);
        check("restart_icw3", {56'h0, icw3}, 64'h02);
        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b1; rd_n = 1'b0;
        repeat (5) @(negedge clk);
        check("midread_oe", {63'h0, bus_oe}, {63'h0, RB});
        rst = 1'b1;
        #1;
        check("rst_midread_outs", all_outs(), 64'h0);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
